// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// ---------------
// Round-robin write arbiter that shares one FIFO write port among NREQ
// producers.
//
// Each producer uses a valid/ready handshake. A granted producer may write
// up to BURST words before the grant is released. Every new grant costs one
// idle arbitration cycle. The block also sequences a one-cycle FIFO
// synchronous reset when flush_req is raised.
//
// Ports:
//   Clk, Rst      clock; synchronous, active-high reset
//   req_valid     per-requester data valid
//   req_data      packed data; requester i sits at [i*DW +: DW]
//   req_ready     per-requester accept (at most one bit high)
//   fifo_full     FIFO FULL flag; stalls the current grant
//   fifo_wr       FIFO write strobe
//   fifo_din      FIFO write data (zero when fifo_wr is low)
//   fifo_rst      registered FIFO reset pulse
//   flush_req     level request to flush the FIFO
//   flush_done    one-cycle pulse when a flush completes
//   grant_idx     currently granted requester
//   busy          high while granting or flushing
//
// Optional build macro FIFO_ARB_STATS_EN adds per-requester 16-bit
// saturating transfer counters. These are read through stat_sel / stat_count,
// and stat_count has one cycle of latency.

module fifo_wr_arbiter #(
   parameter int NREQ  = 4,
   parameter int DW    = 32,
   parameter int BURST = 4
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*DW-1:0]        req_data,
   output logic [NREQ-1:0]           req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_wr,
   output logic [DW-1:0]             fifo_din,
   output logic                      fifo_rst,
   input  logic                      flush_req,
   output logic                      flush_done,
   output logic [$clog2(NREQ)-1:0]   grant_idx,
   output logic                      busy
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic [$clog2(NREQ)-1:0]   stat_sel,
   output logic [15:0]               stat_count
`endif
);

   localparam int GW  = $clog2(NREQ);
   localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [GW-1:0]    last_grant_q, last_grant_d;
   logic [GW-1:0]    grant_idx_q, grant_idx_d;
   logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
   logic             fifo_rst_q, fifo_rst_d;
   logic             flush_done_q, flush_done_d;

   logic             pick_found;
   logic [GW-1:0]    pick_idx;
   logic [GW-1:0]    cand_idx;
   int               cand;
   logic [DW-1:0]    sel_data;
   logic             xfer;

   // Round-robin search: start one past the last winner and wrap around.
   // The first valid requester found wins, so each requester gets a fair
   // turn in rotation.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand     = (int'(last_grant_q) + i) % NREQ;
         cand_idx = GW'(cand);
         if (!pick_found && req_valid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Data mux for the granted requester. It uses constant slice bases so
   // each lane is a plain wire selection.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (GW'(i) == grant_idx_q) begin
            sel_data = req_data[i*DW +: DW];
         end
      end
   end

   // Next-state and handshake logic.
   // A flush request outranks arbitration. In GRANT, ready is withheld while
   // the FIFO is full, which stalls the grant without ending the burst.
   // Ready is also withheld while a flush is pending, so the flush can take
   // over on the next cycle.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_idx_d  = grant_idx_q;
      beat_cnt_d   = beat_cnt_q;
      fifo_rst_d   = 1'b0;
      flush_done_d = 1'b0;
      req_ready    = '0;
      fifo_wr      = 1'b0;
      fifo_din     = '0;
      xfer         = 1'b0;

      case (state_q)
         IDLE: begin
            if (flush_req) begin
               state_d    = FLUSH;
               fifo_rst_d = 1'b1;
            end else if (pick_found) begin
               state_d      = GRANT;
               grant_idx_d  = pick_idx;
               last_grant_d = pick_idx;
               beat_cnt_d   = '0;
            end
         end

         GRANT: begin
            req_ready[grant_idx_q] = !fifo_full && !flush_req;
            xfer = req_valid[grant_idx_q] && !fifo_full && !flush_req;
            if (xfer) begin
               fifo_wr    = 1'b1;
               fifo_din   = sel_data;
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (flush_req || !req_valid[grant_idx_q] ||
                (xfer && (beat_cnt_q == BEAT_LAST))) begin
               state_d = IDLE;
            end
         end

         FLUSH: begin
            state_d      = IDLE;
            flush_done_d = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. last_grant resets to the top index so that requester 0
   // is the first one searched.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= IDLE;
         last_grant_q <= GW'(NREQ - 1);
         grant_idx_q  <= '0;
         beat_cnt_q   <= '0;
         fifo_rst_q   <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_idx_q  <= grant_idx_d;
         beat_cnt_q   <= beat_cnt_d;
         fifo_rst_q   <= fifo_rst_d;
         flush_done_q <= flush_done_d;
      end
   end

   assign grant_idx  = grant_idx_q;
   assign fifo_rst   = fifo_rst_q;
   assign flush_done = flush_done_q;
   assign busy       = (state_q != IDLE);

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stat_cnt_q [NREQ];
   logic [15:0] stat_cnt_d [NREQ];
   logic [15:0] stat_count_q, stat_count_d;

   // Per-requester accepted-word counters. Each counter saturates at
   // all-ones instead of wrapping. The readback value is registered.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         stat_cnt_d[i] = stat_cnt_q[i];
      end
      if (xfer && (stat_cnt_q[grant_idx_q] != 16'hFFFF)) begin
         stat_cnt_d[grant_idx_q] = stat_cnt_q[grant_idx_q] + 16'd1;
      end
      stat_count_d = (int'(stat_sel) < NREQ) ? stat_cnt_q[stat_sel] : 16'd0;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < NREQ; i++) begin
            stat_cnt_q[i] <= 16'd0;
         end
         stat_count_q <= 16'd0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            stat_cnt_q[i] <= stat_cnt_d[i];
         end
         stat_count_q <= stat_count_d;
      end
   end

   assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter.
// Each producer presents {id, word number} and advances on a handshake.
// Expected FIFO words are pushed to a scoreboard queue as stimulus is
// planned, and popped whenever the DUT writes.
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int DW    = 32;
   localparam int BURST = 4;
   localparam int GW    = 2;

   logic               Clk = 1'b0;
   logic               Rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               fifo_full;
   logic               fifo_wr;
   logic [DW-1:0]      fifo_din;
   logic               fifo_rst;
   logic               flush_req;
   logic               flush_done;
   logic [GW-1:0]      grant_idx;
   logic               busy;
`ifdef FIFO_ARB_STATS_EN
   logic [GW-1:0]      stat_sel;
   logic [15:0]        stat_count;
`endif

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_wr    (fifo_wr),
      .fifo_din   (fifo_din),
      .fifo_rst   (fifo_rst),
      .flush_req  (flush_req),
      .flush_done (flush_done),
      .grant_idx  (grant_idx),
      .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stat_sel   (stat_sel),
      .stat_count (stat_count)
`endif
   );

   always #5 Clk = ~Clk;

   int            errors = 0;
   int            checks = 0;
   int            wr_seen = 0;
   logic [DW-1:0] exp_q[$];
   int            prod_word[NREQ];
   int            exp_word[NREQ];

   typedef struct packed {
      logic [NREQ-1:0] valid;
      logic            full;
      logic            flush;
      logic [NREQ-1:0] ready;
      logic            wr;
      logic [GW-1:0]   gidx;
      logic            busy;
   } vec_t;

   vec_t tbl[12];

   function automatic logic [DW-1:0] word_of(input int r, input int w);
      return {8'(r), 24'(w)};
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, want %0h at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic drive_data();
      for (int i = 0; i < NREQ; i++) begin
         req_data[i*DW +: DW] = word_of(i, prod_word[i]);
      end
   endtask

   task automatic push_exp(input int r, input int n);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(word_of(r, exp_word[r]));
         exp_word[r]++;
      end
   endtask

   // Drives inputs for this cycle and waits until the negedge to sample.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic f,
                                input logic fl);
      req_valid = v;
      fifo_full = f;
      flush_req = fl;
      drive_data();
      @(negedge Clk);
   endtask

   // Runs the per-cycle scoreboard and one-hot checks, advances producers,
   // and moves to just after the next posedge.
   task automatic end_cycle();
      checkOutput("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (fifo_wr) begin
         wr_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: got %0h, want no write at t=%0t",
                     fifo_din, $time);
         end else begin
            checkOutput("fifo_din", fifo_din, exp_q.pop_front());
         end
      end else begin
         checkOutput("din_zero", fifo_din, '0);
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_ready[i]) prod_word[i]++;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic reset_dut();
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      @(negedge Clk);
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_wr", 32'(fifo_wr), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_fifo_rst", 32'(fifo_rst), 32'd0);
      checkOutput("rst_flush_done", 32'(flush_done), 32'd0);
      checkOutput("rst_grant_idx", 32'(grant_idx), 32'd0);
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) begin
         prod_word[i] = 0;
         exp_word[i]  = 0;
      end
      drive_data();
   endtask

   task automatic check_empty(input string name);
      checkOutput(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Rst       = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      flush_req = 1'b0;
      req_data  = '0;
`ifdef FIFO_ARB_STATS_EN
      stat_sel  = '0;
`endif
      for (int i = 0; i < NREQ; i++) begin
         prod_word[i] = 0;
         exp_word[i]  = 0;
      end

      // Requesters 0 and 2 valid: 0, 2, then back to 0, each burst after a bubble.
      $display("[TB] two requesters, round robin");
      reset_dut();
      push_exp(0, 4);
      push_exp(2, 4);
      push_exp(0, 4);
      wr_seen = 0;
      for (int c = 0; c < 15; c++) begin
         applyStimulus(4'b0101, 1'b0, 1'b0);
         if (c == 0)  checkOutput("t1_idle_busy", 32'(busy), 32'd0);
         if (c == 6)  checkOutput("t1_gidx2", 32'(grant_idx), 32'd2);
         if (c == 11) checkOutput("t1_gidx0", 32'(grant_idx), 32'd0);
         end_cycle();
         if (c == 9) checkOutput("t1_wr_8of10", 32'(wr_seen), 32'd8);
      end
      checkOutput("t1_wr_12of15", 32'(wr_seen), 32'd12);
      applyStimulus(4'b0000, 1'b0, 1'b0);
      end_cycle();
      check_empty("t1_queue_empty");

      // All four requesters valid: order is 0, 1, 2, 3, 0 with 4 words each.
      $display("[TB] four requesters, full rotation");
      reset_dut();
      push_exp(0, 4);
      push_exp(1, 4);
      push_exp(2, 4);
      push_exp(3, 4);
      push_exp(0, 4);
      wr_seen = 0;
      for (int c = 0; c < 25; c++) begin
         applyStimulus(4'b1111, 1'b0, 1'b0);
         if ((c % 5) != 0) checkOutput("t2_gidx", 32'(grant_idx), 32'((c / 5) % 4));
         end_cycle();
      end
      checkOutput("t2_wr_count", 32'(wr_seen), 32'd20);
      applyStimulus(4'b0000, 1'b0, 1'b0);
      end_cycle();
      check_empty("t2_queue_empty");

      // Table: requester 1 stalled by FULL for 3 cycles mid-burst, then a
      // second grant to the same requester ended by dropping valid.
      $display("[TB] FULL stall table");
      tbl[0]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
      tbl[1]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
      tbl[2]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
      tbl[3]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1};
      tbl[4]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1};
      tbl[5]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1};
      tbl[6]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
      tbl[7]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
      tbl[8]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
      tbl[9]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
      tbl[10] = '{4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b1};
      tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
      reset_dut();
      for (int k = 0; k < 12; k++) begin
         applyStimulus(tbl[k].valid, tbl[k].full, tbl[k].flush);
         if (tbl[k].wr) push_exp(1, 1);
         checkOutput("tbl_ready", 32'(req_ready), 32'(tbl[k].ready));
         checkOutput("tbl_wr", 32'(fifo_wr), 32'(tbl[k].wr));
         checkOutput("tbl_gidx", 32'(grant_idx), 32'(tbl[k].gidx));
         checkOutput("tbl_busy", 32'(busy), 32'(tbl[k].busy));
         end_cycle();
      end
      check_empty("tbl_queue_empty");

      // Requester 3 sends 2 words and drops valid; the next grant wraps to 0.
      $display("[TB] early valid drop and wrap");
      reset_dut();
      applyStimulus(4'b1000, 1'b0, 1'b0);
      checkOutput("t4_bubble_ready", 32'(req_ready), 32'd0);
      end_cycle();
      applyStimulus(4'b1000, 1'b0, 1'b0);
      push_exp(3, 1);
      checkOutput("t4_gidx3", 32'(grant_idx), 32'd3);
      end_cycle();
      applyStimulus(4'b1000, 1'b0, 1'b0);
      push_exp(3, 1);
      end_cycle();
      applyStimulus(4'b0101, 1'b0, 1'b0);
      checkOutput("t4_drop_wr", 32'(fifo_wr), 32'd0);
      checkOutput("t4_drop_ready", 32'(req_ready), 32'b1000);
      end_cycle();
      applyStimulus(4'b0101, 1'b0, 1'b0);
      checkOutput("t4_idle_busy", 32'(busy), 32'd0);
      end_cycle();
      applyStimulus(4'b0101, 1'b0, 1'b0);
      push_exp(0, 1);
      checkOutput("t4_wrap_gidx0", 32'(grant_idx), 32'd0);
      checkOutput("t4_wrap_wr", 32'(fifo_wr), 32'd1);
      end_cycle();
      applyStimulus(4'b0000, 1'b0, 1'b0);
      checkOutput("t4_end_wr", 32'(fifo_wr), 32'd0);
      end_cycle();
      applyStimulus(4'b0000, 1'b0, 1'b0);
      checkOutput("t4_end_busy", 32'(busy), 32'd0);
      end_cycle();
      check_empty("t4_queue_empty");

      // A flush raised mid-burst, then a flush request held across two flushes.
      $display("[TB] flush sequencing");
      reset_dut();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      end_cycle();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      push_exp(0, 1);
      end_cycle();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      push_exp(0, 1);
      end_cycle();
      applyStimulus(4'b0001, 1'b0, 1'b1);
      checkOutput("fl_ready_drop", 32'(req_ready), 32'd0);
      checkOutput("fl_no_wr", 32'(fifo_wr), 32'd0);
      checkOutput("fl_busy_grant", 32'(busy), 32'd1);
      end_cycle();
      applyStimulus(4'b0001, 1'b0, 1'b1);
      checkOutput("fl_idle_busy", 32'(busy), 32'd0);
      checkOutput("fl_idle_rst", 32'(fifo_rst), 32'd0);
      end_cycle();
      applyStimulus(4'b0001, 1'b0, 1'b1);
      checkOutput("fl_fifo_rst", 32'(fifo_rst), 32'd1);
      checkOutput("fl_busy", 32'(busy), 32'd1);
      checkOutput("fl_done_early", 32'(flush_done), 32'd0);
      checkOutput("fl_flush_wr", 32'(fifo_wr), 32'd0);
      end_cycle();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      checkOutput("fl_done", 32'(flush_done), 32'd1);
      checkOutput("fl_rst_off", 32'(fifo_rst), 32'd0);
      checkOutput("fl_done_busy", 32'(busy), 32'd0);
      end_cycle();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      push_exp(0, 1);
      checkOutput("fl_resume_wr", 32'(fifo_wr), 32'd1);
      checkOutput("fl_done_pulse", 32'(flush_done), 32'd0);
      end_cycle();
      applyStimulus(4'b0000, 1'b0, 1'b0);
      end_cycle();
      applyStimulus(4'b0000, 1'b0, 1'b1);
      end_cycle();
      applyStimulus(4'b0000, 1'b0, 1'b1);
      checkOutput("fl2_rst_a", 32'(fifo_rst), 32'd1);
      end_cycle();
      applyStimulus(4'b0000, 1'b0, 1'b1);
      checkOutput("fl2_done_a", 32'(flush_done), 32'd1);
      checkOutput("fl2_idle", 32'(busy), 32'd0);
      end_cycle();
      applyStimulus(4'b0000, 1'b0, 1'b0);
      checkOutput("fl2_rst_b", 32'(fifo_rst), 32'd1);
      checkOutput("fl2_busy_b", 32'(busy), 32'd1);
      end_cycle();
      applyStimulus(4'b0000, 1'b0, 1'b0);
      checkOutput("fl2_done_b", 32'(flush_done), 32'd1);
      end_cycle();
      applyStimulus(4'b0000, 1'b0, 1'b0);
      checkOutput("fl2_done_end", 32'(flush_done), 32'd0);
      end_cycle();
      check_empty("fl_queue_empty");

      // Reset applied mid-burst; reset_dut checks that the grant is abandoned.
      $display("[TB] reset mid-burst");
      reset_dut();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      end_cycle();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      push_exp(0, 1);
      end_cycle();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      reset_dut();
      req_valid = '0;

`ifdef FIFO_ARB_STATS_EN
      // Saturation: flood requester 2 past 65535 words, while requester 0 stays idle.
      $display("[TB] statistics saturation");
      reset_dut();
      begin
         int acc;
         acc = 0;
         stat_sel  = 2'd2;
         req_valid = 4'b0100;
         for (int c = 0; c < 90000 && acc < 65540; c++) begin
            @(negedge Clk);
            if (fifo_wr) acc++;
            @(posedge Clk);
            #1;
         end
         checkOutput("st_words", 32'(acc), 32'd65540);
      end
      req_valid = '0;
      repeat (3) @(posedge Clk);
      #1;
      @(negedge Clk);
      checkOutput("st_sat", 32'(stat_count), 32'hFFFF);
      stat_sel = 2'd0;
      @(posedge Clk);
      #1;
      @(negedge Clk);
      checkOutput("st_idle", 32'(stat_count), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
